// File: rtl/vga_syncmod.sv
// 640x480@60 VGA timing generator: scan-position counters, delayed active-low syncs,
// display-active flag and frame-start strobe. Define VGA_FRAME_CNT_EN to add oFrameCnt.
module vga_syncmod #(
    parameter logic [9:0] SA         = 10'd96,
    parameter logic [9:0] SB         = 10'd48,
    parameter logic [9:0] SC         = 10'd640,
    parameter logic [9:0] SD         = 10'd16,
    parameter logic [9:0] SE         = 10'd800,
    parameter logic [9:0] SO         = 10'd2,
    parameter logic [9:0] SP         = 10'd33,
    parameter logic [9:0] SQ         = 10'd480,
    parameter logic [9:0] SR         = 10'd10,
    parameter logic [9:0] SS         = 10'd525,
    parameter int         SYNC_DELAY = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [19:0] oAddr,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        oActive,
    output logic        oFrameStart
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] oFrameCnt
`endif
);

    localparam logic [9:0] H_ACT_LO = SA + SB;
    localparam logic [9:0] H_ACT_HI = SA + SB + SC - 10'd1;
    localparam logic [9:0] V_ACT_LO = SO + SP;
    localparam logic [9:0] V_ACT_HI = SO + SP + SQ - 10'd1;

    logic [9:0] c1_q, c1_d;
    logic [9:0] c2_q, c2_d;
    logic       first_q;
    logic       hs_raw, vs_raw, act_raw;

    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        c1_d = c1_q + 10'd1;
        c2_d = c2_q;
        if (c1_q == SE - 10'd1) begin
            c1_d = '0;
            c2_d = (c2_q == SS - 10'd1) ? '0 : c2_q + 10'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            c1_q    <= '0;
            c2_q    <= '0;
            first_q <= 1'b1;
        end else begin
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            first_q <= 1'b0;
        end
    end

    assign oAddr       = {c1_q, c2_q};
    assign oFrameStart = (c1_q == 10'd0) && (c2_q == 10'd0) && !first_q;

    assign hs_raw  = (c1_q >= SA);
    assign vs_raw  = (c2_q >= SO);
    assign act_raw = (c1_q >= H_ACT_LO) && (c1_q <= H_ACT_HI) &&
                     (c2_q >= V_ACT_LO) && (c2_q <= V_ACT_HI);

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign HSYNC   = hs_raw;
            assign VSYNC   = vs_raw;
            assign oActive = act_raw;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_q, vs_q, act_q;

            // NOTE: delay stages reset to idle levels so a mid-frame reset flushes any pulse in flight.
            always_ff @(posedge CLOCK or negedge RESET) begin
                if (!RESET) begin
                    hs_q  <= '1;
                    vs_q  <= '1;
                    act_q <= '0;
                end else begin
                    hs_q  <= (hs_q << 1)  | SYNC_DELAY'(hs_raw);
                    vs_q  <= (vs_q << 1)  | SYNC_DELAY'(vs_raw);
                    act_q <= (act_q << 1) | SYNC_DELAY'(act_raw);
                end
            end

            assign HSYNC   = hs_q[SYNC_DELAY-1];
            assign VSYNC   = vs_q[SYNC_DELAY-1];
            assign oActive = act_q[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = oFrameStart ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign oFrameCnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_syncmod.sv
// Scoreboard bench for vga_syncmod: a full-size instance for line timing and a
// shrunken-timing instance for whole-frame, wrap and mid-frame reset behaviour.
module tb_vga_syncmod;

    localparam int D_SA = 96, D_SB = 48, D_SC = 640, D_SE = 800;
    localparam int D_SO = 2,  D_SP = 33, D_SQ = 480, D_SS = 525;
    localparam int S_SA = 4,  S_SB = 3,  S_SC = 8,   S_SD = 2, S_SE = 17;
    localparam int S_SO = 1,  S_SP = 2,  S_SQ = 4,   S_SR = 2, S_SS = 9;
    localparam int S_FRAME = S_SE * S_SS;
    localparam logic [2:0] RST_V = 3'b110;   // {hsync, vsync, active} while reset

    logic        clk = 1'b0;
    logic        rst_d_n, rst_s_n;
    logic [19:0] addr_d, addr_s;
    logic        hs_d, vs_d, act_d, fs_d;
    logic        hs_s, vs_s, act_s, fs_s;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fcnt_d, fcnt_s;
`endif

    int n_total = 0;
    int n_bad   = 0;

    int md_c1, md_c2, ms_c1, ms_c2;
    bit md_first, ms_first;
    logic [2:0] qd[$];
    logic [2:0] qs[$];

    always #5 clk = ~clk;

    vga_syncmod #(.SYNC_DELAY(2)) dut_d (
        .CLOCK(clk), .RESET(rst_d_n), .oAddr(addr_d), .HSYNC(hs_d), .VSYNC(vs_d),
        .oActive(act_d), .oFrameStart(fs_d)
`ifdef VGA_FRAME_CNT_EN
        , .oFrameCnt(fcnt_d)
`endif
    );

    vga_syncmod #(
        .SA(10'd4), .SB(10'd3), .SC(10'd8), .SD(10'd2), .SE(10'd17),
        .SO(10'd1), .SP(10'd2), .SQ(10'd4), .SR(10'd2), .SS(10'd9),
        .SYNC_DELAY(2)
    ) dut_s (
        .CLOCK(clk), .RESET(rst_s_n), .oAddr(addr_s), .HSYNC(hs_s), .VSYNC(vs_s),
        .oActive(act_s), .oFrameStart(fs_s)
`ifdef VGA_FRAME_CNT_EN
        , .oFrameCnt(fcnt_s)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] raw_f(input int c1, input int c2, input int sa, input int sb,
                                         input int sc, input int so, input int sp, input int sq);
        logic hs, vs, act;
        hs  = (c1 >= sa);
        vs  = (c2 >= so);
        act = (c1 >= sa + sb) && (c1 < sa + sb + sc) && (c2 >= so + sp) && (c2 < so + sp + sq);
        return {hs, vs, act};
    endfunction

    // One clock: advance both reference models, push the raw levels of the state
    // just left, pop the level due out of the 2-deep delay and compare everything.
    task automatic tick();
        logic [2:0] e;
        logic       fs_e;
        @(posedge clk);
        #1;
        if (!rst_d_n) begin
            md_c1 = 0; md_c2 = 0; md_first = 1'b1;
            qd.delete(); qd.push_back(RST_V);
            e = RST_V;
        end else begin
            qd.push_back(raw_f(md_c1, md_c2, D_SA, D_SB, D_SC, D_SO, D_SP, D_SQ));
            if (md_c1 == D_SE - 1) begin
                md_c1 = 0;
                md_c2 = (md_c2 == D_SS - 1) ? 0 : md_c2 + 1;
            end else begin
                md_c1++;
            end
            md_first = 1'b0;
            e = qd.pop_front();
        end
        fs_e = (md_c1 == 0) && (md_c2 == 0) && !md_first;
        check("dflt_out", 32'({addr_d, hs_d, vs_d, act_d, fs_d}),
              32'({md_c1[9:0], md_c2[9:0], e, fs_e}));

        if (!rst_s_n) begin
            ms_c1 = 0; ms_c2 = 0; ms_first = 1'b1;
            qs.delete(); qs.push_back(RST_V);
            e = RST_V;
        end else begin
            qs.push_back(raw_f(ms_c1, ms_c2, S_SA, S_SB, S_SC, S_SO, S_SP, S_SQ));
            if (ms_c1 == S_SE - 1) begin
                ms_c1 = 0;
                ms_c2 = (ms_c2 == S_SS - 1) ? 0 : ms_c2 + 1;
            end else begin
                ms_c1++;
            end
            ms_first = 1'b0;
            e = qs.pop_front();
        end
        fs_e = (ms_c1 == 0) && (ms_c2 == 0) && !ms_first;
        check("small_out", 32'({addr_s, hs_s, vs_s, act_s, fs_s}),
              32'({ms_c1[9:0], ms_c2[9:0], e, fs_e}));
    endtask

    int hs_low_cnt = 0, hs_first = -1, act_first = -1;
    int vs_low_cnt = 0, act_cnt = 0, fs_cnt = 0, fs_at = -1;

    initial begin
        rst_d_n = 1'b0;
        rst_s_n = 1'b0;
        repeat (5) tick();
        check("rst_addr",  32'(addr_d), 32'h0);
        check("rst_hsync", 32'(hs_d),   32'h1);
        check("rst_vsync", 32'(vs_d),   32'h1);
        check("rst_act",   32'(act_d),  32'h0);
        check("rst_fs",    32'(fs_d),   32'h0);

        @(negedge clk);
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;

        for (int k = 1; k <= 28200; k++) begin
            tick();
            if (k <= 800 && !hs_d) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (k == 799) check("addr_799", 32'(addr_d), 32'({10'd799, 10'd0}));
            if (k == 800) check("addr_800", 32'(addr_d), 32'({10'd0, 10'd1}));
            if (act_d && act_first < 0) act_first = k;

            if (k <= S_FRAME) begin
                if (!vs_s) vs_low_cnt++;
                if (act_s) act_cnt++;
                if (fs_s) begin
                    fs_cnt++;
                    fs_at = k;
                end
            end
            // Mid-frame reset of the small instance at column 10, row 5 of its second frame.
            if (k == S_FRAME + 5 * S_SE + 10) begin
                check("pre_rst_addr", 32'(addr_s), 32'({10'd10, 10'd5}));
                rst_s_n = 1'b0;
                #1;
                check("midrst_addr",  32'(addr_s), 32'h0);
                check("midrst_hsync", 32'(hs_s),   32'h1);
                check("midrst_vsync", 32'(vs_s),   32'h1);
                check("midrst_act",   32'(act_s),  32'h0);
            end
            if (k == 251) begin
                @(negedge clk);
                rst_s_n = 1'b1;
            end
            if (k == 252) check("restart_addr", 32'(addr_s), 32'({10'd1, 10'd0}));
            if (k == 252 + S_FRAME - 1) check("restart_fs", 32'(fs_s), 32'h1);
`ifdef VGA_FRAME_CNT_EN
            if (k == 252 + 3 * S_FRAME) check("fcnt_3", 32'(fcnt_s), 32'd3);
            if (k == 720) dut_s.frame_cnt_q = 16'hFFFF;
            if (k == 252 + 4 * S_FRAME) check("fcnt_wrap", 32'(fcnt_s), 32'd0);
`endif
        end

        check("hs_low_cnt",  32'(hs_low_cnt), 32'd96);
        check("hs_first",    32'(hs_first),   32'd2);
        check("act_first",   32'(act_first),  32'(35 * 800 + 144 + 2));
        check("vs_low_cnt",  32'(vs_low_cnt), 32'(S_SO * S_SE));
        check("act_cnt",     32'(act_cnt),    32'(S_SC * S_SQ));
        check("fs_cnt",      32'(fs_cnt),     32'd1);
        check("fs_at",       32'(fs_at),      32'(S_FRAME));
`ifdef VGA_FRAME_CNT_EN
        check("fcnt_dflt",   32'(fcnt_d),     32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
